// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
// stopwatch_ctrl : debounced run/clear buttons driving a run/pause/idle FSM
//                  and a resumable tick prescaler for downstream BCD counters.
// Revision       : 1.0
// ============================================================================
module stopwatch_ctrl #(
    parameter int TICK_DIV        = 50_000_000,
    parameter int DEBOUNCE_CYCLES = 500_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_btn_run,
    input  logic       i_btn_clr,
    output logic       o_tick,
    output logic       o_clear,
    output logic       o_running,
    output logic [1:0] o_state
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [PW-1:0] C_PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [DW-1:0] C_DEB_MAX   = DW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10
    } state_t;

    logic [1:0] btn_raw;
    logic [1:0] press;

    assign btn_raw = {i_btn_clr, i_btn_run};

    // Index 0 is the run button, index 1 the clear button.
    for (genvar gi = 0; gi < 2; gi++) begin : g_btn
        logic [1:0]    sync_q;
        logic          deb_q;
        logic          deb_prev_q;
        logic [DW-1:0] cnt_q;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                sync_q     <= '0;
                deb_q      <= 1'b0;
                deb_prev_q <= 1'b0;
                cnt_q      <= '0;
            end else begin
                sync_q     <= {sync_q[0], btn_raw[gi]};
                deb_prev_q <= deb_q;
                if (sync_q[1] == deb_q) begin
                    cnt_q <= '0;
                end else if (cnt_q == C_DEB_MAX) begin
                    deb_q <= sync_q[1];
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end

        assign press[gi] = deb_q & ~deb_prev_q;
    end

    state_t        state_q;
    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_d;
    logic          wrap_d;
    logic          tick_q;
    logic          clear_q;

    always_comb begin
        presc_d = presc_q + 1'b1;
        wrap_d  = 1'b0;
        if (presc_q == C_PRESC_MAX) begin
            presc_d = '0;
            wrap_d  = 1'b1;
        end
    end

    // Clear has priority over run; a wrap in the clearing cycle never ticks.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            presc_q <= '0;
            tick_q  <= 1'b0;
            clear_q <= 1'b0;
        end else begin
            tick_q  <= 1'b0;
            clear_q <= 1'b0;
            if (press[1]) begin
                state_q <= S_IDLE;
                presc_q <= '0;
                clear_q <= 1'b1;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        presc_q <= '0;
                        if (press[0]) state_q <= S_RUN;
                    end
                    S_RUN: begin
                        presc_q <= presc_d;
                        tick_q  <= wrap_d;
                        if (press[0]) state_q <= S_PAUSE;
                    end
                    S_PAUSE: begin
                        if (press[0]) state_q <= S_RUN;
                    end
                    default: begin
                        state_q <= S_IDLE;
                        presc_q <= '0;
                    end
                endcase
            end
        end
    end

    assign o_tick    = tick_q;
    assign o_clear   = clear_q;
    assign o_state   = state_q;
    assign o_running = (state_q == S_RUN);

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
// tb_stopwatch_ctrl : randomized and directed checks of stopwatch_ctrl
//                     against a cycle-level behavioural reference model.
// Revision          : 1.0
// ============================================================================
module tb_stopwatch_ctrl;

    localparam int TD = 4;
    localparam int DB = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_run = 1'b0;
    logic       btn_clr = 1'b0;
    logic       o_tick, o_clear, o_running;
    logic [1:0] o_state;
    wire  [4:0] dut_out = {o_state, o_running, o_tick, o_clear};

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    stopwatch_ctrl #(.TICK_DIV(TD), .DEBOUNCE_CYCLES(DB)) dut (
        .clk       (clk),
        .reset     (reset),
        .i_btn_run (btn_run),
        .i_btn_clr (btn_clr),
        .o_tick    (o_tick),
        .o_clear   (o_clear),
        .o_running (o_running),
        .o_state   (o_state)
    );

    // Reference model: buttons seen two clocks late, a level is accepted after
    // DB consecutive disagreeing cycles; m_runs counts RUN cycles modulo TD.
    bit m_s1[2], m_s2[2], m_deb[2], m_prev[2];
    int m_cnt[2];
    int m_state, m_runs;
    bit m_tick, m_clear;

    task automatic model_reset();
        for (int b = 0; b < 2; b++) begin
            m_s1[b] = 0; m_s2[b] = 0; m_deb[b] = 0; m_prev[b] = 0; m_cnt[b] = 0;
        end
        m_state = 0; m_runs = 0; m_tick = 0; m_clear = 0;
    endtask

    task automatic model_edge(input bit run, input bit clr);
        bit p[2];
        bit raw[2];
        raw[0] = run;
        raw[1] = clr;
        for (int b = 0; b < 2; b++) p[b] = m_deb[b] && !m_prev[b];
        m_tick  = 0;
        m_clear = 0;
        if (p[1]) begin
            m_state = 0; m_runs = 0; m_clear = 1;
        end else if (m_state == 1) begin
            m_runs = m_runs + 1;
            if (m_runs == TD) begin
                m_runs = 0;
                m_tick = 1;
            end
            if (p[0]) m_state = 2;
        end else if (m_state == 0) begin
            m_runs = 0;
            if (p[0]) m_state = 1;
        end else if (p[0]) begin
            m_state = 1;
        end
        for (int b = 0; b < 2; b++) begin
            m_prev[b] = m_deb[b];
            if (m_s2[b] != m_deb[b]) begin
                m_cnt[b] = m_cnt[b] + 1;
                if (m_cnt[b] == DB) begin
                    m_deb[b] = m_s2[b];
                    m_cnt[b] = 0;
                end
            end else begin
                m_cnt[b] = 0;
            end
            m_s2[b] = m_s1[b];
            m_s1[b] = raw[b];
        end
    endtask

    function automatic logic [4:0] m_out();
        logic [1:0] st;
        st = 2'(m_state);
        return {st, (m_state == 1), m_tick, m_clear};
    endfunction

    task automatic step(input bit run, input bit clr);
        btn_run = run;
        btn_clr = clr;
        model_edge(run, clr);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic quiet_clear();
        for (int i = 0; i < 6; i++) step(0, 1);
        for (int i = 0; i < 10; i++) step(0, 0);
    endtask

    task automatic test_reset();
        #1;
        n_checks++;
        if (dut_out !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_async got %b want %b", dut_out, 5'b0);
        end
        model_reset();
        @(posedge clk);
        #1;
        n_checks++;
        if (dut_out !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_held got %b want %b", dut_out, 5'b0);
        end
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(0, 0);
            n_checks++;
            if (dut_out !== m_out()) begin
                n_fail++;
                $display("FAIL reset_release cyc %0d got %b want %b", i, dut_out, m_out());
            end
        end
    endtask

    task automatic test_run_hold();
        int entry = -1, first_tick = -1, ticks = 0, changes = 0;
        logic [1:0] prev_st = o_state;
        for (int i = 0; i < 40; i++) begin
            step(i < 20, 0);
            n_checks++;
            if (dut_out !== m_out()) begin
                n_fail++;
                $display("FAIL run_hold cyc %0d got %b want %b", i, dut_out, m_out());
            end
            if (o_state !== prev_st) changes++;
            prev_st = o_state;
            if (entry < 0 && o_state == 2'b01) entry = i;
            if (o_tick) begin
                ticks++;
                if (first_tick < 0) first_tick = i;
            end
        end
        n_checks++;
        if (entry < 0 || entry > 6 || changes != 1) begin
            n_fail++;
            $display("FAIL run_hold_entry got entry %0d changes %0d want entry<=6 changes 1", entry, changes);
        end
        n_checks++;
        if (first_tick != entry + TD || ticks != (39 - entry) / TD) begin
            n_fail++;
            $display("FAIL run_hold_ticks got first %0d count %0d want first %0d count %0d",
                     first_tick, ticks, entry + TD, (39 - entry) / TD);
        end
    endtask

    task automatic test_bounce();
        bit pat[11] = '{1, 0, 1, 1, 0, 0, 1, 0, 1, 1, 0};
        int entry = -1, changes = 0;
        logic [1:0] prev_st;
        quiet_clear();
        prev_st = o_state;
        for (int i = 0; i < 30; i++) begin
            step((i < 11) ? pat[i] : (i < 25), 0);
            n_checks++;
            if (dut_out !== m_out()) begin
                n_fail++;
                $display("FAIL bounce cyc %0d got %b want %b", i, dut_out, m_out());
            end
            if (o_state !== prev_st) changes++;
            prev_st = o_state;
            if (entry < 0 && o_state == 2'b01) entry = i;
        end
        n_checks++;
        if (changes != 1 || entry < 11 + DB) begin
            n_fail++;
            $display("FAIL bounce_event got entry %0d changes %0d want entry>=%0d changes 1", entry, changes, 11 + DB);
        end
    endtask

    task automatic test_pause_resume();
        int pause_at = -1, resume_at = -1, tick_after = -1, pause_ticks = 0, run_before = 0;
        quiet_clear();
        for (int i = 0; i < 80; i++) begin
            step((i < 5) || (i >= 10 && i < 15) || (i >= 60 && i < 65), 0);
            n_checks++;
            if (dut_out !== m_out()) begin
                n_fail++;
                $display("FAIL pause_resume cyc %0d got %b want %b", i, dut_out, m_out());
            end
            if (pause_at < 0 && o_state == 2'b10) pause_at = i;
            if (pause_at < 0 && o_state == 2'b01) run_before++;
            if (pause_at >= 0 && resume_at < 0 && o_state == 2'b10 && i > pause_at && o_tick) pause_ticks++;
            if (pause_at >= 0 && resume_at < 0 && o_state == 2'b01) resume_at = i;
            if (resume_at >= 0 && tick_after < 0 && o_tick) tick_after = i;
        end
        n_checks++;
        if (pause_at < 0 || run_before % TD != 2 || resume_at - pause_at != 50 || pause_ticks != 0) begin
            n_fail++;
            $display("FAIL pause_hold got pause %0d runs %0d resume %0d ticks %0d want runs%%4=2 len 50 ticks 0",
                     pause_at, run_before, resume_at, pause_ticks);
        end
        n_checks++;
        if (resume_at < 0 || tick_after != resume_at + 2) begin
            n_fail++;
            $display("FAIL resume_tick got %0d want %0d", tick_after, resume_at + 2);
        end
    endtask

    task automatic test_same_cycle();
        int clears = 0, bad = 0;
        bit seen = 0;
        for (int i = 0; i < 16; i++) begin
            step(i < 6, i < 6);
            n_checks++;
            if (dut_out !== m_out()) begin
                n_fail++;
                $display("FAIL same_cycle cyc %0d got %b want %b", i, dut_out, m_out());
            end
            if (o_clear) begin
                clears++;
                seen = 1;
            end
            if (seen && (o_tick || o_state != 2'b00)) bad++;
        end
        n_checks++;
        if (clears != 1 || bad != 0) begin
            n_fail++;
            $display("FAIL same_cycle_priority got clears %0d bad %0d want 1 0", clears, bad);
        end
    endtask

    task automatic test_reset_mid_run();
        int guard = 0, bad = 0;
        for (int i = 0; i < 5; i++) step(1, 0);
        while (!(m_state == 1 && m_runs == 3) && guard < 40) begin
            step(0, 0);
            guard++;
        end
        n_checks++;
        if (guard >= 40 || o_state !== 2'b01) begin
            n_fail++;
            $display("FAIL mid_run_setup got state %b guard %0d want 01", o_state, guard);
        end
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if (dut_out !== 5'b0) begin
            n_fail++;
            $display("FAIL mid_run_reset got %b want %b", dut_out, 5'b0);
        end
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 25; i++) begin
            step(0, 0);
            if (o_tick || o_clear || o_state != 2'b00) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL after_reset_quiet got %0d active cycles want 0", bad);
        end
        for (int i = 0; i < 12; i++) step(i < 5, 0);
        n_checks++;
        if (o_state !== 2'b01 || dut_out !== m_out()) begin
            n_fail++;
            $display("FAIL after_reset_run got %b want %b", dut_out, m_out());
        end
    endtask

    task automatic test_clr_idle();
        int clears = 0, bad = 0;
        quiet_clear();
        for (int i = 0; i < 14; i++) begin
            step(0, i < 5);
            n_checks++;
            if (dut_out !== m_out()) begin
                n_fail++;
                $display("FAIL clr_idle cyc %0d got %b want %b", i, dut_out, m_out());
            end
            if (o_clear) clears++;
            if (o_state != 2'b00) bad++;
        end
        n_checks++;
        if (clears != 1 || bad != 0) begin
            n_fail++;
            $display("FAIL clr_idle_pulse got clears %0d non-idle %0d want 1 0", clears, bad);
        end
    endtask

    task automatic test_hold_through_reset();
        int entry = -1;
        btn_run = 1'b1;
        do_reset();
        for (int i = 0; i < 14; i++) begin
            step(i < 10, 0);
            n_checks++;
            if (dut_out !== m_out()) begin
                n_fail++;
                $display("FAIL hold_reset cyc %0d got %b want %b", i, dut_out, m_out());
            end
            if (entry < 0 && o_state == 2'b01) entry = i;
        end
        n_checks++;
        if (entry < DB || entry > 6) begin
            n_fail++;
            $display("FAIL hold_reset_press got entry %0d want %0d..6", entry, DB);
        end
    endtask

    task automatic test_random();
        int  len[2] = '{0, 0};
        bit  lvl[2] = '{0, 0};
        int  errs = 0;
        for (int i = 0; i < 1500; i++) begin
            for (int b = 0; b < 2; b++) begin
                if (len[b] == 0) begin
                    lvl[b] = (b == 0) ? bit'($urandom_range(0, 1)) : ($urandom_range(0, 5) == 0);
                    len[b] = $urandom_range(1, 8);
                end
                len[b]--;
            end
            if ($urandom_range(0, 299) == 0) do_reset();
            step(lvl[0], lvl[1]);
            n_checks++;
            if (dut_out !== m_out()) begin
                n_fail++;
                errs++;
                if (errs < 10) $display("FAIL random cyc %0d got %b want %b", i, dut_out, m_out());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_run_hold();
        test_bounce();
        test_pause_resume();
        test_same_cycle();
        test_reset_mid_run();
        test_clr_idle();
        test_hold_through_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
